cache_set_array: RTL and testbench
==================================

CACHE_SET_ARRAY -- requirements
Module: cache_set_array

Interface
REQ-001 SHALL have parameter WAYS, default 2, number of ways per set (power of two, 1..8).
REQ-002 SHALL have parameter INDEX_W, default 10, set index width; SETS = 2^INDEX_W.
REQ-003 SHALL have parameter TAG_W, default 18, stored tag width.
REQ-004 SHALL have parameter WORDS, default 4, words per line (power of two); OFF_W = log2(WORDS).
REQ-005 SHALL have parameter WORD_W, default 32, word width (multiple of 8); LINE_W = WORDS*WORD_W.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  1  request present; req_ready  out  1  request accepted when both high at a clk edge.
REQ-009 req_op  in  2  00 READ, 01 WRITE, 10 FILL, 11 reserved.
REQ-010 req_index  in  INDEX_W; req_tag  in  TAG_W; req_word  in  OFF_W; req_byte_en  in  WORD_W/8.
REQ-011 req_wdata  in  WORD_W  store data; req_line  in  LINE_W  fill data; req_way  in  log2(WAYS) (min 1)  fill target way.
REQ-012 inv_all  in  1  single-cycle pulse, invalidate entire array.
REQ-013 rsp_valid  out  1; rsp_hit  out  1; rsp_way  out  log2(WAYS); rsp_rdata  out  WORD_W; rsp_line  out  LINE_W.
REQ-014 rsp_victim_way  out  log2(WAYS); rsp_victim_valid  out  1; rsp_victim_dirty  out  1; rsp_victim_tag  out  TAG_W.
REQ-015 busy  out  1  invalidate sweep in progress.

Function
REQ-016 Per set per way SHALL store tag, valid, dirty, line; per set a round-robin pointer (log2(WAYS) bits); storage SHALL be inferred synchronous-read arrays, no vendor IP.
REQ-017 FSM states SWEEP, IDLE; req_ready SHALL be 0 in SWEEP.
REQ-018 SWEEP: one set per cycle, index 0..SETS-1 ascending, clears valid, dirty, pointer; line data and tags untouched; exits to IDLE after set SETS-1 (exactly SETS cycles).
REQ-019 IDLE: inv_all=1 SHALL enter SWEEP next cycle at index 0; an accepted request in the same cycle SHALL still complete and respond; inv_all during SWEEP ignored.
REQ-020 READ/WRITE accepted at edge N SHALL produce rsp_valid=1 for exactly the cycle after edge N+1 (latency 1); FILL and reserved ops SHALL produce no response.
REQ-021 Hit: valid && tag==req_tag for a way; rsp_way = lowest hitting way; rsp_line = that way's line; rsp_rdata = word req_word of it; on miss rsp_way=0, rsp_line/rsp_rdata=0.
REQ-022 Victim: lowest-numbered invalid way if any, else pointer value; rsp_victim_valid/dirty/tag from that way; reported on every response, hit or miss.
REQ-023 WRITE hit SHALL merge req_wdata into word req_word under req_byte_en in the cycle after acceptance; dirty set only if req_byte_en nonzero; rsp_rdata returns pre-write word; WRITE miss modifies nothing.
REQ-024 FILL SHALL write req_line, req_tag, valid=1, dirty=0 into way req_way of req_index and advance that set's pointer to (req_way+1) mod WAYS.
REQ-025 After accepting WRITE or FILL, req_ready SHALL be 0 for the next cycle (one bubble); after READ, req_ready SHALL stay 1 (back-to-back READs at one per cycle).
REQ-026 req_valid with req_ready=0 SHALL be ignored (no state change, no response).
REQ-027 WAYS=1: victim always way 0, pointer unused.

Reset
REQ-028 rst=1 at an edge SHALL: enter SWEEP at index 0, drop any pending response and pending write, drive rsp_valid=0, rsp_hit=0, all rsp_* data fields 0, req_ready=0, busy=1 next cycle.
REQ-029 rst asserted mid-SWEEP SHALL restart the sweep at index 0; after rst release SETS cycles elapse before req_ready=1.

Verification (WAYS=2, INDEX_W=4, TAG_W=18, WORDS=4, WORD_W=32)
REQ-030 rst 1 cycle -> busy=1, req_ready=0 for exactly 16 cycles, then req_ready=1; READ idx 3 tag 0x155 -> rsp_hit=0, rsp_victim_way=0, rsp_victim_valid=0.
REQ-031 FILL idx 3 way 0 tag 0x155 line word2=0xDEADBEEF; READ idx 3 tag 0x155 word 2 -> one cycle later rsp_hit=1, rsp_way=0, rsp_rdata=0xDEADBEEF, victim way 1 invalid.
REQ-032 WRITE idx 3 tag 0x155 word 2 byte_en 0011 data 0x00001234 -> rsp_rdata=0xDEADBEEF, next READ -> 0xDEAD1234, victim-report on way 0 shows dirty=1 once way 1 filled.
REQ-033 FILL both ways of idx 5 (way0 then way1) -> pointer 0; READ miss idx 5 -> rsp_victim_way=0, rsp_victim_valid=1; FILL way 0 -> next miss victim way 1.
REQ-034 Back-to-back READs idx 0..7 every cycle -> 8 consecutive rsp_valid cycles, each 1 cycle after its request; WRITE followed immediately by READ -> req_ready=0 for the one cycle after WRITE.
REQ-035 inv_all in IDLE with READ accepted same cycle -> READ responds, then busy=1 for 16 cycles, all later lookups miss; rst at sweep index 9 -> sweep restarts, 16 further cycles.

Source files
------------

// File: rtl/cache_set_array.sv
// Set-associative cache tag/data array with per-set round-robin replacement.
// Requests are looked up in a two-stage pipeline: storage is read on the
// accepting edge and the response is registered one edge later. A sweep
// invalidates the whole array one set per cycle after reset or inv_all.
module cache_set_array #(
    parameter int unsigned WAYS    = 2,
    parameter int unsigned INDEX_W = 10,
    parameter int unsigned TAG_W   = 18,
    parameter int unsigned WORDS   = 4,
    parameter int unsigned WORD_W  = 32,
    localparam int unsigned SETS   = 1 << INDEX_W,
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int unsigned OFF_W  = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int unsigned BE_W   = WORD_W / 8,
    localparam int unsigned LINE_W = WORDS * WORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [INDEX_W-1:0] req_index,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic [OFF_W-1:0]   req_word,
    input  logic [BE_W-1:0]    req_byte_en,
    input  logic [WORD_W-1:0]  req_wdata,
    input  logic [LINE_W-1:0]  req_line,
    input  logic [WAY_W-1:0]   req_way,
    input  logic               inv_all,
    output logic               rsp_valid,
    output logic               rsp_hit,
    output logic [WAY_W-1:0]   rsp_way,
    output logic [WORD_W-1:0]  rsp_rdata,
    output logic [LINE_W-1:0]  rsp_line,
    output logic [WAY_W-1:0]   rsp_victim_way,
    output logic               rsp_victim_valid,
    output logic               rsp_victim_dirty,
    output logic [TAG_W-1:0]   rsp_victim_tag,
    output logic               busy
);

    typedef enum logic [0:0] {StSweep, StIdle} state_e;

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpFill  = 2'b10;

    // Control
    state_e             state_q, state_d;
    logic [INDEX_W-1:0] sweep_idx_q, sweep_idx_d;
    logic               bubble_q, bubble_d;
    logic               accept;
    logic               sweep_en;
    logic               fill_en;
    logic [WAY_W-1:0]   fill_ptr;

    // Storage
    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic [LINE_W-1:0] line_mem  [SETS][WAYS];
    logic [WAYS-1:0]   valid_mem [SETS];
    logic [WAYS-1:0]   dirty_mem [SETS];
    logic [WAY_W-1:0]  ptr_mem   [SETS];

    // Synchronous read registers
    logic [TAG_W-1:0]  rd_tag_q  [WAYS];
    logic [LINE_W-1:0] rd_line_q [WAYS];
    logic [WAYS-1:0]   rd_valid_q;
    logic [WAYS-1:0]   rd_dirty_q;
    logic [WAY_W-1:0]  rd_ptr_q;

    // Lookup stage
    logic               s1_valid_q, s1_valid_d;
    logic               s1_write_q, s1_write_d;
    logic [INDEX_W-1:0] s1_index_q, s1_index_d;
    logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
    logic [OFF_W-1:0]   s1_word_q, s1_word_d;
    logic [BE_W-1:0]    s1_be_q, s1_be_d;
    logic [WORD_W-1:0]  s1_wdata_q, s1_wdata_d;

    logic               hit;
    logic               vic_found;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   vic_way;
    logic [LINE_W-1:0]  hit_line;
    logic [LINE_W-1:0]  wr_line;
    logic [WORD_W-1:0]  hit_word;
    logic [WORD_W-1:0]  merged_word;
    logic               wr_en;

    // Response registers
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic [WAY_W-1:0]   rsp_way_q, rsp_way_d;
    logic [WORD_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [LINE_W-1:0]  rsp_line_q, rsp_line_d;
    logic [WAY_W-1:0]   rsp_vway_q, rsp_vway_d;
    logic               rsp_vvalid_q, rsp_vvalid_d;
    logic               rsp_vdirty_q, rsp_vdirty_d;
    logic [TAG_W-1:0]   rsp_vtag_q, rsp_vtag_d;

    // FSM state register; reset restarts the sweep from set 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSweep;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // FSM next state: sweep one set per cycle, inv_all only honoured in idle
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        unique case (state_q)
            StSweep: begin
                sweep_idx_d = sweep_idx_q + 1'b1;
                if (sweep_idx_q == {INDEX_W{1'b1}}) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (inv_all) begin
                    state_d     = StSweep;
                    sweep_idx_d = '0;
                end
            end
            default: state_d = StSweep;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready = (state_q == StIdle) && !bubble_q;
        busy      = (state_q == StSweep);
        sweep_en  = (state_q == StSweep);
    end

    // Request acceptance and capture of the lookup stage
    always_comb begin
        accept     = req_valid && req_ready;
        bubble_d   = accept && ((req_op == OpWrite) || (req_op == OpFill));
        s1_valid_d = accept && ((req_op == OpRead) || (req_op == OpWrite));
        s1_write_d = (req_op == OpWrite);
        s1_index_d = req_index;
        s1_tag_d   = req_tag;
        s1_word_d  = req_word;
        s1_be_d    = req_byte_en;
        s1_wdata_d = req_wdata;
        fill_en    = accept && (req_op == OpFill) && !rst;
        fill_ptr   = (WAYS == 1) ? '0 : req_way + 1'b1;
    end

    // Lookup stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            bubble_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            bubble_q   <= bubble_d;
        end
        s1_write_q <= s1_write_d;
        s1_index_q <= s1_index_d;
        s1_tag_q   <= s1_tag_d;
        s1_word_q  <= s1_word_d;
        s1_be_q    <= s1_be_d;
        s1_wdata_q <= s1_wdata_d;
    end

    // Tag compare, victim selection and write merge on the read-out set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && rd_valid_q[w] && (rd_tag_q[w] == s1_tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        vic_found = 1'b0;
        vic_way   = (WAYS == 1) ? '0 : rd_ptr_q;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!vic_found && !rd_valid_q[w]) begin
                vic_found = 1'b1;
                vic_way   = WAY_W'(w);
            end
        end
        hit_line    = rd_line_q[hit_way];
        hit_word    = hit_line[s1_word_q*WORD_W +: WORD_W];
        merged_word = hit_word;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (s1_be_q[b]) begin
                merged_word[b*8 +: 8] = s1_wdata_q[b*8 +: 8];
            end
        end
        wr_line = hit_line;
        wr_line[s1_word_q*WORD_W +: WORD_W] = merged_word;
        wr_en = s1_valid_q && s1_write_q && hit && !rst;
    end

    // Response contents; all fields read zero when no response is due
    always_comb begin
        rsp_valid_d  = s1_valid_q;
        rsp_hit_d    = 1'b0;
        rsp_way_d    = '0;
        rsp_rdata_d  = '0;
        rsp_line_d   = '0;
        rsp_vway_d   = '0;
        rsp_vvalid_d = 1'b0;
        rsp_vdirty_d = 1'b0;
        rsp_vtag_d   = '0;
        if (s1_valid_q) begin
            rsp_hit_d = hit;
            if (hit) begin
                rsp_way_d   = hit_way;
                rsp_line_d  = hit_line;
                rsp_rdata_d = hit_word;
            end
            rsp_vway_d   = vic_way;
            rsp_vvalid_d = rd_valid_q[vic_way];
            rsp_vdirty_d = rd_dirty_q[vic_way];
            rsp_vtag_d   = rd_tag_q[vic_way];
        end
    end

    // Response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_rdata_q  <= '0;
            rsp_line_q   <= '0;
            rsp_vway_q   <= '0;
            rsp_vvalid_q <= 1'b0;
            rsp_vdirty_q <= 1'b0;
            rsp_vtag_q   <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_way_q    <= rsp_way_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_line_q   <= rsp_line_d;
            rsp_vway_q   <= rsp_vway_d;
            rsp_vvalid_q <= rsp_vvalid_d;
            rsp_vdirty_q <= rsp_vdirty_d;
            rsp_vtag_q   <= rsp_vtag_d;
        end
    end

    // Storage: synchronous read of the requested set plus fill/write/sweep updates
    always_ff @(posedge clk) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
            rd_tag_q[w]  <= tag_mem[req_index][w];
            rd_line_q[w] <= line_mem[req_index][w];
        end
        rd_valid_q <= valid_mem[req_index];
        rd_dirty_q <= dirty_mem[req_index];
        rd_ptr_q   <= ptr_mem[req_index];
        if (fill_en) begin
            tag_mem[req_index][req_way]   <= req_tag;
            line_mem[req_index][req_way]  <= req_line;
            valid_mem[req_index][req_way] <= 1'b1;
            dirty_mem[req_index][req_way] <= 1'b0;
            ptr_mem[req_index]            <= fill_ptr;
        end
        if (wr_en) begin
            line_mem[s1_index_q][hit_way] <= wr_line;
            if (|s1_be_q) begin
                dirty_mem[s1_index_q][hit_way] <= 1'b1;
            end
        end
        // Last so invalidation beats an in-flight dirty update to the same set
        if (sweep_en) begin
            valid_mem[sweep_idx_q] <= '0;
            dirty_mem[sweep_idx_q] <= '0;
            ptr_mem[sweep_idx_q]   <= '0;
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_hit          = rsp_hit_q;
    assign rsp_way          = rsp_way_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_line         = rsp_line_q;
    assign rsp_victim_way   = rsp_vway_q;
    assign rsp_victim_valid = rsp_vvalid_q;
    assign rsp_victim_dirty = rsp_vdirty_q;
    assign rsp_victim_tag   = rsp_vtag_q;

endmodule

// File: tb/tb_cache_set_array.sv
// Self-checking bench for cache_set_array: directed scenarios followed by
// random traffic, all compared against a transaction-level cache model.
module tb_cache_set_array;

    localparam int WAYS = 2;
    localparam int INDEX_W = 4;
    localparam int TAG_W = 18;
    localparam int WORDS = 4;
    localparam int WORD_W = 32;
    localparam int SETS = 16;
    localparam int LINE_W = 128;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         req_word;
    logic [3:0]         req_byte_en;
    logic [WORD_W-1:0]  req_wdata;
    logic [LINE_W-1:0]  req_line;
    logic [0:0]         req_way;
    logic               inv_all;
    logic               rsp_valid;
    logic               rsp_hit;
    logic [0:0]         rsp_way;
    logic [WORD_W-1:0]  rsp_rdata;
    logic [LINE_W-1:0]  rsp_line;
    logic [0:0]         rsp_victim_way;
    logic               rsp_victim_valid;
    logic               rsp_victim_dirty;
    logic [TAG_W-1:0]   rsp_victim_tag;
    logic               busy;

    always #5 clk = ~clk;

    cache_set_array #(
        .WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .WORDS(WORDS), .WORD_W(WORD_W)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_index(req_index), .req_tag(req_tag), .req_word(req_word),
        .req_byte_en(req_byte_en), .req_wdata(req_wdata), .req_line(req_line),
        .req_way(req_way), .inv_all(inv_all), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .rsp_way(rsp_way), .rsp_rdata(rsp_rdata), .rsp_line(rsp_line),
        .rsp_victim_way(rsp_victim_way), .rsp_victim_valid(rsp_victim_valid),
        .rsp_victim_dirty(rsp_victim_dirty), .rsp_victim_tag(rsp_victim_tag), .busy(busy)
    );

    typedef struct {
        bit              v;
        bit              hit;
        int              way;
        logic [127:0]    line;
        logic [31:0]     rdata;
        int              vway;
        bit              vval;
        bit              vdirty;
        logic [17:0]     vtag;
        bit              vtagk;
        bit              wr;
        int              set;
        int              word;
        logic [3:0]      be;
        logic [31:0]     wdata;
    } pend_t;

    // Reference model state
    logic [17:0]  m_tag   [SETS][WAYS];
    bit           m_tagk  [SETS][WAYS];
    bit           m_val   [SETS][WAYS];
    bit           m_dirty [SETS][WAYS];
    logic [127:0] m_line  [SETS][WAYS];
    int           m_ptr   [SETS];
    int           m_sweep;
    bit           m_bubble;
    pend_t        m_pend;
    pend_t        m_rsp;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic pend_t zero_rsp();
        pend_t p;
        p = '{default: '0};
        p.vtagk = 1'b1;
        return p;
    endfunction

    function automatic bit m_ready();
        return (m_sweep == 0) && !m_bubble;
    endfunction

    function automatic void invalidate_all();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_val[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endfunction

    function automatic pend_t lookup(input int s, input logic [17:0] tag, input int word,
                                     input bit wr, input logic [3:0] be,
                                     input logic [31:0] wd);
        pend_t p;
        p = zero_rsp();
        p.v = 1'b1;
        p.wr = wr; p.set = s; p.word = word; p.be = be; p.wdata = wd;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (m_val[s][w] && m_tag[s][w] == tag) begin
                p.hit = 1'b1; p.way = w;
            end
        end
        if (p.hit) begin
            p.line = m_line[s][p.way];
            p.rdata = p.line[word*32 +: 32];
        end
        p.vway = m_ptr[s];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!m_val[s][w]) p.vway = w;
        end
        p.vval = m_val[s][p.vway];
        p.vdirty = m_dirty[s][p.vway];
        p.vtag = m_tag[s][p.vway];
        p.vtagk = m_tagk[s][p.vway];
        return p;
    endfunction

    // One clock: check ready/busy, advance the model across the edge, check the response
    task automatic step();
        bit acc;
        logic [127:0] l;
        logic [31:0] wd;
        int s;
        int w;
        chk("req_ready", 128'(req_ready), 128'(m_ready()));
        chk("busy", 128'(busy), 128'(m_sweep != 0));
        acc = req_valid && m_ready();
        @(posedge clk);
        #1;
        if (rst) begin
            m_rsp = zero_rsp();
            m_pend = zero_rsp();
            m_pend.v = 1'b0;
            m_bubble = 1'b0;
            m_sweep = SETS;
            invalidate_all();
        end else begin
            m_rsp = m_pend;
            if (!m_pend.v) m_rsp = zero_rsp();
            if (m_pend.v && m_pend.wr && m_pend.hit) begin
                s = m_pend.set;
                w = m_pend.way;
                l = m_line[s][w];
                wd = l[m_pend.word*32 +: 32];
                for (int b = 0; b < 4; b++) begin
                    if (m_pend.be[b]) wd[b*8 +: 8] = m_pend.wdata[b*8 +: 8];
                end
                l[m_pend.word*32 +: 32] = wd;
                m_line[s][w] = l;
                if (m_pend.be != 4'b0 && m_val[s][w]) m_dirty[s][w] = 1'b1;
            end
            m_pend = zero_rsp();
            m_pend.v = 1'b0;
            if (acc) begin
                s = int'(req_index);
                if (req_op == 2'b10) begin
                    w = int'(req_way);
                    m_tag[s][w] = req_tag;
                    m_tagk[s][w] = 1'b1;
                    m_line[s][w] = req_line;
                    m_val[s][w] = 1'b1;
                    m_dirty[s][w] = 1'b0;
                    m_ptr[s] = (w + 1) % WAYS;
                end else if (req_op == 2'b00 || req_op == 2'b01) begin
                    m_pend = lookup(s, req_tag, int'(req_word), req_op == 2'b01,
                                    req_byte_en, req_wdata);
                end
            end
            m_bubble = acc && (req_op == 2'b01 || req_op == 2'b10);
            if (m_sweep > 0) begin
                m_sweep--;
            end else if (inv_all) begin
                m_sweep = SETS;
                invalidate_all();
            end
        end
        chk("rsp_valid", 128'(rsp_valid), 128'(m_rsp.v));
        chk("rsp_hit", 128'(rsp_hit), 128'(m_rsp.hit));
        chk("rsp_way", 128'(rsp_way), 128'(m_rsp.way));
        chk("rsp_rdata", 128'(rsp_rdata), 128'(m_rsp.rdata));
        chk("rsp_line", rsp_line, m_rsp.line);
        chk("rsp_victim_way", 128'(rsp_victim_way), 128'(m_rsp.vway));
        chk("rsp_victim_valid", 128'(rsp_victim_valid), 128'(m_rsp.vval));
        chk("rsp_victim_dirty", 128'(rsp_victim_dirty), 128'(m_rsp.vdirty));
        if (m_rsp.vtagk) chk("rsp_victim_tag", 128'(rsp_victim_tag), 128'(m_rsp.vtag));
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            inv_all = 1'b0;
            rst = 1'b0;
        end
    endtask

    // Hold a request until the model says it is taken (bounded)
    task automatic req(input logic [1:0] op, input int idx, input logic [17:0] tag,
                       input int word, input logic [3:0] be, input logic [31:0] wd,
                       input logic [127:0] ln, input int way);
        bit done;
        done = 1'b0;
        req_op = op; req_index = 4'(idx); req_tag = tag; req_word = 2'(word);
        req_byte_en = be; req_wdata = wd; req_line = ln; req_way = 1'(way);
        req_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            done = m_ready();
            step();
            inv_all = 1'b0;
        end
        req_valid = 1'b0;
        chk("req_accept_bound", 128'(done), 128'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] ln;
        rst = 1'b1; req_valid = 1'b0; inv_all = 1'b0; req_op = 2'b00; req_index = '0;
        req_tag = '0; req_word = '0; req_byte_en = '0; req_wdata = '0; req_line = '0;
        req_way = '0;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_tagk[s][w] = 1'b0; m_tag[s][w] = '0; m_line[s][w] = '0;
            end
        end
        @(posedge clk);
        #1;
        invalidate_all();
        m_sweep = SETS; m_bubble = 1'b0;
        m_pend = zero_rsp(); m_pend.v = 1'b0;
        chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("reset_ready", 128'(req_ready), 128'(0));
        chk("reset_busy", 128'(busy), 128'(1));
        chk("reset_rdata", 128'(rsp_rdata), 128'(0));
        rst = 1'b0;

        // Sweep lasts exactly SETS cycles
        idle(16);
        chk("ready_after_sweep", 128'(req_ready), 128'(1));
        req(2'b00, 3, 18'h155, 0, 4'h0, 32'h0, 128'h0, 0);
        idle(1);
        chk("first_read_miss", 128'(rsp_hit), 128'(0));
        chk("first_read_vvalid", 128'(rsp_victim_valid), 128'(0));

        // Fill then read hit
        ln = {32'h11111111, 32'hDEADBEEF, 32'h22222222, 32'h33333333};
        req(2'b10, 3, 18'h155, 0, 4'h0, 32'h0, ln, 0);
        req(2'b00, 3, 18'h155, 2, 4'h0, 32'h0, 128'h0, 0);
        idle(1);
        chk("fill_read_rdata", 128'(rsp_rdata), 128'(32'hDEADBEEF));
        chk("fill_read_vway", 128'(rsp_victim_way), 128'(1));

        // Partial write returns old word, next read sees merge
        req(2'b01, 3, 18'h155, 2, 4'b0011, 32'h00001234, 128'h0, 0);
        idle(1);
        chk("write_old_word", 128'(rsp_rdata), 128'(32'hDEADBEEF));
        req(2'b00, 3, 18'h155, 2, 4'h0, 32'h0, 128'h0, 0);
        idle(1);
        chk("merged_word", 128'(rsp_rdata), 128'(32'hDEAD1234));
        req(2'b10, 3, 18'h2AA, 0, 4'h0, 32'h0, {4{32'h0BADF00D}}, 1);
        req(2'b00, 3, 18'h3FF, 0, 4'h0, 32'h0, 128'h0, 0);
        idle(1);
        chk("dirty_victim_way", 128'(rsp_victim_way), 128'(0));
        chk("dirty_victim_dirty", 128'(rsp_victim_dirty), 128'(1));

        // Round-robin replacement
        req(2'b10, 5, 18'h1, 0, 4'h0, 32'h0, {4{32'hA5A5A5A5}}, 0);
        req(2'b10, 5, 18'h2, 0, 4'h0, 32'h0, {4{32'h5A5A5A5A}}, 1);
        req(2'b00, 5, 18'h3, 0, 4'h0, 32'h0, 128'h0, 0);
        idle(1);
        chk("rr_victim0", 128'(rsp_victim_way), 128'(0));
        req(2'b10, 5, 18'h4, 0, 4'h0, 32'h0, {4{32'h01234567}}, 0);
        req(2'b00, 5, 18'h3, 0, 4'h0, 32'h0, 128'h0, 0);
        idle(1);
        chk("rr_victim1", 128'(rsp_victim_way), 128'(1));

        // Back-to-back reads, then write bubble
        for (int i = 0; i < 8; i++) req(2'b00, i, 18'h155, i % 4, 4'h0, 32'h0, 128'h0, 0);
        idle(1);
        req(2'b01, 3, 18'h155, 1, 4'hF, 32'hCAFEF00D, 128'h0, 0);
        chk("write_bubble", 128'(req_ready), 128'(0));
        req(2'b00, 3, 18'h155, 1, 4'h0, 32'h0, 128'h0, 0);
        idle(1);

        // inv_all with a read in the same cycle
        inv_all = 1'b1;
        req(2'b00, 3, 18'h155, 2, 4'h0, 32'h0, 128'h0, 0);
        idle(1);
        chk("inv_read_hit", 128'(rsp_hit), 128'(1));
        chk("inv_busy", 128'(busy), 128'(1));
        idle(15);
        chk("inv_ready", 128'(req_ready), 128'(1));
        req(2'b00, 3, 18'h155, 2, 4'h0, 32'h0, 128'h0, 0);
        idle(1);
        chk("after_inv_miss", 128'(rsp_hit), 128'(0));

        // Reset at sweep index 9 restarts the sweep
        inv_all = 1'b1;
        idle(1);
        idle(9);
        rst = 1'b1;
        idle(1);
        chk("rst_mid_busy", 128'(busy), 128'(1));
        idle(15);
        chk("rst_mid_not_ready", 128'(req_ready), 128'(0));
        idle(1);
        chk("rst_mid_ready", 128'(req_ready), 128'(1));

        // Random traffic over a few sets and tags
        for (int i = 0; i < 800; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_op = 2'($urandom_range(0, 3));
            req_index = 4'($urandom_range(0, 3));
            req_tag = 18'(32'h100 + $urandom_range(0, 2));
            req_word = 2'($urandom);
            req_byte_en = 4'($urandom);
            req_wdata = $urandom;
            req_line = {$urandom, $urandom, $urandom, $urandom};
            req_way = 1'($urandom);
            inv_all = ($urandom_range(0, 79) == 0);
            rst = ($urandom_range(0, 249) == 0);
            step();
        end
        inv_all = 1'b0;
        rst = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
